dequant_zigzag_writer: RTL and testbench
========================================

# dequant_zigzag_writer

Upstream neighbour of the IDCT stage in the Milestone 3 decode path. Accepts the lossless-decoded coefficient stream, 64 values per 8x8 block in zigzag order, dequantizes each by a power-of-two quantization matrix and writes S' into a ping-pong (two-bank) dual-port RAM in row-major order. The IDCT stage reads a full bank and releases it. Bank-level handshakes provide backpressure on the decoder.

## Interface
Parameters:
- COEF_W, 16, signed input coefficient width
- OUT_W, 32, written S' word width, sign-extended

Ports:
- CLOCK_50_I  in  1  50 MHz clock, the only clock
- reset  in  1  synchronous, active-high reset
- dqz_enable  in  1  block enable; when low, no new block is started
- q_sel  in  1  quantization matrix select (0 = Q0, 1 = Q1); sampled on the first coefficient of each block
- coef_data  in  COEF_W  signed decoded coefficient, zigzag order
- coef_valid  in  1  coef_data valid
- coef_ready  out  1  block accepts coef_data this cycle
- dp_address  out  7  [6] = bank, [5:0] = row*8+col
- dp_write_data  out  OUT_W  dequantized S'
- dp_we  out  1  active-high write strobe
- bank_full  out  2  per-bank flag: holds a complete block
- idct_release  in  2  one-cycle pulse per bank; IDCT has consumed it
- block_done  out  1  one-cycle pulse after the 64th write of a block

## Operation
- States: IDLE, FILL, FLUSH.
- IDLE to FILL: dqz_enable=1 and write bank (wr_bank) not full.
- FILL: coef_ready=1. Each transfer (coef_valid & coef_ready) increments k (0..63) and advances the zigzag (r,c).
- FILL to FLUSH: on the transfer with k=63.
- FLUSH: perform the last write; set bank_full[wr_bank]; pulse block_done; toggle wr_bank; go to IDLE.
- Zigzag walk starts at (0,0) with direction up-right.
  - Up-right: if c==7, r++ and flip direction. Else if r==0, c++ and flip. Else r--, c++.
  - Down-left: if r==7, c++ and flip. Else if c==0, r++ and flip. Else r++, c--.
- Shift amount s from d = r+c.
  - Q0 (values 8,4,8,16,32,64): d=0 gives 3; d=1 gives 2; d=2..3 gives 3; d=4..5 gives 4; d=6..7 gives 5; d>=8 gives 6.
  - Q1 (values 8,2,4,8,16,32): d=0 gives 3; d=1..3 gives 1; d=4..5 gives 2; d=6..7 gives 3; d=8..9 gives 4; d>=10 gives 5.
- S' = sign_extend(coef_data) <<< s, computed at OUT_W. No overflow is possible for COEF_W=16.
- q_sel is latched at k=0 and held for the whole block.
- idct_release[b] clears bank_full[b]. If release and set hit the same bank in the same cycle, set wins.
- A full wr_bank holds the FSM in IDLE with coef_ready=0.
- dqz_enable low mid-block does not abort the block; the block completes.

## Timing
- Reset values: coef_ready=0, dp_we=0, dp_address=0, dp_write_data=0, bank_full=2'b00, block_done=0. Also k=0, (r,c)=(0,0), wr_bank=0, state IDLE.
- Write latency is 1 cycle: a transfer at edge t produces dp_we=1 with registered address and data during cycle t+1.
- Throughput is 1 coefficient/cycle. Minimum block time is 66 cycles, including IDLE re-entry.
- block_done and the bank_full set occur on the same edge, one cycle after the 64th dp_we.
- Reset mid-block discards the partial block, clears both banks and de-asserts dp_we on the next edge.
- coef_valid low stalls k; no write is issued.

## Configuration
- DQZ_CLIP_EN defined: S' is saturated to [-2048, 2047] before the write, because IDCT multipliers expect 12-bit S'.
- DQZ_CLIP_EN undefined: the full shifted value is sign-extended to OUT_W, with no clipping.

## Test plan
- Reset, then 64 coefficients of value 1 with q_sel=0 and valid held high -> dp_address sequence 0,1,8,16,9,2,...,63 and data at addr 0 = 8, addr 1 = 4, addr 63 = 64. block_done fires 65 cycles after the first transfer; bank_full=01.
- Same block with q_sel=1 and coefficient -3 -> addr 0 = -24, addr 8 = -6, addr 63 = -96. q_sel toggled mid-block has no effect.
- Two blocks back-to-back with no release -> second goes to bank 1 (dp_address[6]=1). A third block sees coef_ready=0 until an idct_release=01 pulse, then writes bank 0.
- idct_release[0] on the same cycle bank 0 is set -> bank_full[0] stays 1.
- Reset asserted at k=30 -> all outputs at reset values next cycle. The restarted block begins at address 0, bank 0.
- With DQZ_CLIP_EN defined, coefficient 1000 at d=10 with q_sel=0 (shift 6 gives 64000) -> 2047 written. Coefficient -1000 -> -2048.

Source files
------------

// File: rtl/dequant_zigzag_writer.sv
// Dequantizes a zigzag-ordered 8x8 coefficient stream by power-of-two shifts and writes
// it row-major into a two-bank S' RAM. Optional macro DQZ_CLIP_EN saturates S' to 12 bits.
module dequant_zigzag_writer #(
  parameter int COEF_W = 16,
  parameter int OUT_W  = 32
) (
  input  logic                     CLOCK_50_I,
  input  logic                     reset,
  input  logic                     dqz_enable,
  input  logic                     q_sel,
  input  logic signed [COEF_W-1:0] coef_data,
  input  logic                     coef_valid,
  output logic                     coef_ready,
  output logic [6:0]               dp_address,
  output logic [OUT_W-1:0]         dp_write_data,
  output logic                     dp_we,
  output logic [1:0]               bank_full,
  input  logic [1:0]               idct_release,
  output logic                     block_done
);

  typedef enum logic [1:0] {IDLE, FILL, FLUSH} state_t;

  state_t state, next_state;

  logic [5:0] k;
  logic [2:0] r, c;
  logic       dir_up;
  logic       wr_bank;
  logic       q_latched;

  logic                    xfer;
  logic                    q_eff;
  logic [3:0]              d;
  logic [2:0]              shift;
  logic [2:0]              r_next, c_next;
  logic                    dir_next;
  logic signed [OUT_W-1:0] coef_ext, shifted, result;

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // A full write bank parks the FSM in IDLE; enable is only consulted between blocks
  always_comb begin
    next_state = state;
    coef_ready = 1'b0;
    case (state)
      IDLE:    if (dqz_enable && !bank_full[wr_bank]) next_state = FILL;
      FILL: begin
        coef_ready = 1'b1;
        if (coef_valid && k == 6'd63) next_state = FLUSH;
      end
      FLUSH:   next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  assign xfer = coef_valid & coef_ready;

  always_comb begin
    r_next   = r;
    c_next   = c;
    dir_next = dir_up;
    if (dir_up) begin
      if (c == 3'd7) begin
        r_next = r + 3'd1; dir_next = 1'b0;
      end else if (r == 3'd0) begin
        c_next = c + 3'd1; dir_next = 1'b0;
      end else begin
        r_next = r - 3'd1; c_next = c + 3'd1;
      end
    end else begin
      if (r == 3'd7) begin
        c_next = c + 3'd1; dir_next = 1'b1;
      end else if (c == 3'd0) begin
        r_next = r + 3'd1; dir_next = 1'b1;
      end else begin
        r_next = r + 3'd1; c_next = c - 3'd1;
      end
    end
  end

  // The matrix select is taken live on the first coefficient, then from the latch
  assign q_eff = (k == 6'd0) ? q_sel : q_latched;
  assign d     = {1'b0, r} + {1'b0, c};

  always_comb begin
    shift = 3'd3;
    if (!q_eff) begin
      case (d)
        4'd0:       shift = 3'd3;
        4'd1:       shift = 3'd2;
        4'd2, 4'd3: shift = 3'd3;
        4'd4, 4'd5: shift = 3'd4;
        4'd6, 4'd7: shift = 3'd5;
        default:    shift = 3'd6;
      endcase
    end else begin
      case (d)
        4'd0:             shift = 3'd3;
        4'd1, 4'd2, 4'd3: shift = 3'd1;
        4'd4, 4'd5:       shift = 3'd2;
        4'd6, 4'd7:       shift = 3'd3;
        4'd8, 4'd9:       shift = 3'd4;
        default:          shift = 3'd5;
      endcase
    end
  end

  assign coef_ext = {{(OUT_W-COEF_W){coef_data[COEF_W-1]}}, coef_data};
  assign shifted  = coef_ext <<< shift;

`ifdef DQZ_CLIP_EN
  // The IDCT multipliers take 12-bit S', so saturate rather than wrap
  always_comb begin
    result = shifted;
    if (shifted > OUT_W'(2047))       result = OUT_W'(2047);
    else if (shifted < OUT_W'(-2048)) result = OUT_W'(-2048);
  end
`else
  assign result = shifted;
`endif

  always_ff @(posedge CLOCK_50_I) begin
    if (reset) begin
      k             <= '0;
      r             <= '0;
      c             <= '0;
      dir_up        <= 1'b1;
      wr_bank       <= 1'b0;
      q_latched     <= 1'b0;
      dp_we         <= 1'b0;
      dp_address    <= '0;
      dp_write_data <= '0;
      bank_full     <= 2'b00;
      block_done    <= 1'b0;
    end else begin
      dp_we      <= xfer;
      block_done <= (state == FLUSH);
      if (xfer) begin
        dp_address    <= {wr_bank, r, c};
        dp_write_data <= result;
        if (k == 6'd0) q_latched <= q_sel;
        if (k == 6'd63) begin
          k      <= '0;
          r      <= '0;
          c      <= '0;
          dir_up <= 1'b1;
        end else begin
          k      <= k + 6'd1;
          r      <= r_next;
          c      <= c_next;
          dir_up <= dir_next;
        end
      end
      if (state == FLUSH) wr_bank <= ~wr_bank;
      // Setting a bank takes priority over a release landing on the same edge
      for (int b = 0; b < 2; b++) begin
        if (state == FLUSH && wr_bank == b[0]) bank_full[b] <= 1'b1;
        else if (idct_release[b])              bank_full[b] <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dequant_zigzag_writer.sv
// Directed, table-driven bench for dequant_zigzag_writer: whole blocks are streamed in,
// captured writes are compared against hand-computed S' values and the JPEG zigzag order.
module tb_dequant_zigzag_writer;

  localparam int COEF_W = 16;
  localparam int OUT_W  = 32;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     dqz_enable;
  logic                     q_sel;
  logic signed [COEF_W-1:0] coef_data;
  logic                     coef_valid;
  logic                     coef_ready;
  logic [6:0]               dp_address;
  logic [OUT_W-1:0]         dp_write_data;
  logic                     dp_we;
  logic [1:0]               bank_full;
  logic [1:0]               idct_release;
  logic                     block_done;

  dequant_zigzag_writer #(.COEF_W(COEF_W), .OUT_W(OUT_W)) dut (
    .CLOCK_50_I   (clk),
    .reset        (reset),
    .dqz_enable   (dqz_enable),
    .q_sel        (q_sel),
    .coef_data    (coef_data),
    .coef_valid   (coef_valid),
    .coef_ready   (coef_ready),
    .dp_address   (dp_address),
    .dp_write_data(dp_write_data),
    .dp_we        (dp_we),
    .bank_full    (bank_full),
    .idct_release (idct_release),
    .block_done   (block_done)
  );

  always #10 clk = ~clk;

  typedef struct {
    int blk;
    int addr;
    int exp;
  } vec_t;

  vec_t vecs[$];
  int   n_vectors = 0;
  int   n_miscompares = 0;

  // Standard JPEG zigzag: position k -> row*8+col
  int zz[64] = '{ 0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
                 12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
                 35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
                 58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  logic [6:0]              addr_log[$];
  logic signed [OUT_W-1:0] mem[128];

  always @(negedge clk) begin
    if (dp_we) begin
      addr_log.push_back(dp_address);
      mem[dp_address] = dp_write_data;
    end
  end

  function automatic int clipExp(input int v);
`ifdef DQZ_CLIP_EN
    if (v > 2047)  return 2047;
    if (v < -2048) return -2048;
`endif
    return v;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    n_vectors++;
    if (actual !== expected) begin
      n_miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Streams nxfer coefficients; returns at the negedge following the last transfer edge
  task automatic applyStimulus(input logic signed [COEF_W-1:0] v, input logic q,
                               input bit toggle_q, input int nxfer);
    int n = 0;
    int guard = 0;
    addr_log.delete();
    coef_data  = v;
    q_sel      = q;
    coef_valid = 1'b1;
    dqz_enable = 1'b1;
    while (n < nxfer && guard < 300) begin
      if (coef_ready) n++;
      q_sel = (toggle_q && n >= 2) ? ~q : q;
      @(negedge clk);
      guard++;
    end
    coef_valid = 1'b0;
    checkOutput("xfer_count", n, nxfer);
  endtask

  task automatic finishBlock(input logic [1:0] rel, input logic [1:0] exp_full);
    checkOutput("last_we", dp_we, 1);
    checkOutput("done_early", block_done, 0);
    idct_release = rel;
    @(negedge clk);
    idct_release = 2'b00;
    checkOutput("block_done", block_done, 1);
    checkOutput("bank_full", bank_full, exp_full);
    @(negedge clk);
    checkOutput("done_pulse", block_done, 0);
  endtask

  task automatic checkAddrSeq(input logic bank);
    int errs = 0;
    checkOutput("write_count", addr_log.size(), 64);
    for (int i = 0; i < 64 && i < addr_log.size(); i++)
      if (addr_log[i] !== {bank, 6'(zz[i])}) errs++;
    checkOutput("addr_seq_errs", errs, 0);
  endtask

  task automatic checkVectors(input int blk);
    foreach (vecs[i])
      if (vecs[i].blk == blk)
        checkOutput($sformatf("blk%0d_addr%0d", blk, vecs[i].addr),
                    longint'(mem[vecs[i].addr]), vecs[i].exp);
  endtask

  task automatic releaseBanks(input logic [1:0] rel);
    idct_release = rel;
    @(negedge clk);
    idct_release = 2'b00;
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_coef_ready"}, coef_ready, 0);
    checkOutput({tag, "_dp_we"}, dp_we, 0);
    checkOutput({tag, "_dp_address"}, dp_address, 0);
    checkOutput({tag, "_dp_write_data"}, dp_write_data, 0);
    checkOutput({tag, "_bank_full"}, bank_full, 0);
    checkOutput({tag, "_block_done"}, block_done, 0);
  endtask

  initial begin
    int busy_errs;

    // blk0: +1, Q0, bank 0
    vecs.push_back('{0,  0,  8}); vecs.push_back('{0,  1,  4});
    vecs.push_back('{0,  8,  4}); vecs.push_back('{0,  9,  8});
    vecs.push_back('{0,  4, 16}); vecs.push_back('{0, 27, 32});
    vecs.push_back('{0, 56, 32}); vecs.push_back('{0, 15, 64});
    vecs.push_back('{0, 63, 64});
    // blk1: -3, Q1 (select toggled mid-block), bank 1
    vecs.push_back('{1,  64, -24}); vecs.push_back('{1,  65,  -6});
    vecs.push_back('{1,  72,  -6}); vecs.push_back('{1,  73,  -6});
    vecs.push_back('{1,  82, -12}); vecs.push_back('{1,  98, -24});
    vecs.push_back('{1, 120, -24}); vecs.push_back('{1, 103, -96});
    vecs.push_back('{1, 127, -96});
    // blk2: +5, Q0, bank 0
    vecs.push_back('{2,  0,  40}); vecs.push_back('{2,  3,  40});
    vecs.push_back('{2, 36, 320}); vecs.push_back('{2, 63, 320});
    // blk3: +2, Q0, bank 0 after reset
    vecs.push_back('{3, 0, 16}); vecs.push_back('{3, 1, 8});
    // blk4: +1000, Q0, bank 1; blk5: -1000, Q0, bank 0
    vecs.push_back('{4, 64, clipExp(8000)}); vecs.push_back('{4, 65, clipExp(4000)});
    vecs.push_back('{4, 95, clipExp(64000)});
    vecs.push_back('{5,  0, clipExp(-8000)}); vecs.push_back('{5, 63, clipExp(-64000)});

    reset        = 1'b1;
    dqz_enable   = 1'b0;
    q_sel        = 1'b0;
    coef_data    = '0;
    coef_valid   = 1'b0;
    idct_release = 2'b00;
    repeat (3) @(negedge clk);
    checkResetValues("rst");
    reset = 1'b0;
    @(negedge clk);

    $display("[TB] block 0: +1, Q0");
    applyStimulus(16'sd1, 1'b0, 1'b0, 64);
    finishBlock(2'b00, 2'b01);
    checkAddrSeq(1'b0);
    checkVectors(0);

    $display("[TB] block 1: -3, Q1, back-to-back");
    applyStimulus(-16'sd3, 1'b1, 1'b1, 64);
    finishBlock(2'b00, 2'b11);
    checkAddrSeq(1'b1);
    checkVectors(1);

    $display("[TB] block 2: waits for bank 0 release");
    coef_valid = 1'b1;
    dqz_enable = 1'b1;
    busy_errs  = 0;
    repeat (10) begin
      if (coef_ready !== 1'b0) busy_errs++;
      @(negedge clk);
    end
    checkOutput("ready_while_full", busy_errs, 0);
    releaseBanks(2'b01);
    applyStimulus(16'sd5, 1'b0, 1'b0, 64);
    finishBlock(2'b01, 2'b11);
    checkAddrSeq(1'b0);
    checkVectors(2);

    $display("[TB] reset mid-block at k=30");
    releaseBanks(2'b11);
    applyStimulus(16'sd7, 1'b0, 1'b0, 30);
    checkOutput("partial_addr_bank", dp_address[6], 1);
    @(negedge clk);
    checkOutput("stall_no_we", dp_we, 0);
    reset = 1'b1;
    @(negedge clk);
    checkResetValues("midrst");
    reset = 1'b0;
    applyStimulus(16'sd2, 1'b0, 1'b0, 64);
    finishBlock(2'b00, 2'b01);
    checkAddrSeq(1'b0);
    checkVectors(3);

    $display("[TB] large coefficients");
    releaseBanks(2'b11);
    applyStimulus(16'sd1000, 1'b0, 1'b0, 64);
    finishBlock(2'b00, 2'b10);
    checkVectors(4);
    releaseBanks(2'b11);
    applyStimulus(-16'sd1000, 1'b0, 1'b0, 64);
    finishBlock(2'b00, 2'b01);
    checkVectors(5);

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule
